// File: rtl/cache_access_profiler.sv
// cache_access_profiler
//   Drives one address/read stream into NUM_CH cache instances in parallel,
//   samples every channel's l1_hit/l2_hit RESP_LAT+1 cycles after each read
//   strobe, and keeps saturating per-channel L1-hit / L2-hit / miss counters.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start, abort      launch a run (IDLE/DONE only) / terminate an active run
//   mode              0 random, 1/3 sequential stride, 2 working-set
//   num_acc           accesses per run
//   base_addr, stride, ws_mask   address generator configuration
//   addr, read        address and one-cycle read strobe to the caches
//   l1_hit, l2_hit    per-channel hit flags, sampled in SAMPLE
//   busy, done, acc_cnt          run status
//   stat_ch, stat_sel, stat_data counter readback (combinational)

// Per-channel hit/miss counters. An access lands in exactly one bucket:
// L1 takes priority over L2, otherwise it is a miss.
module cache_access_profiler_lane #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             smp,
    input  logic             l1,
    input  logic             l2,
    output logic [CNT_W-1:0] l1_cnt,
    output logic [CNT_W-1:0] l2_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            l1_cnt   <= '0;
            l2_cnt   <= '0;
            miss_cnt <= '0;
        end else if (clr) begin
            l1_cnt   <= '0;
            l2_cnt   <= '0;
            miss_cnt <= '0;
        end else if (smp) begin
            // saturate at all-ones instead of wrapping
            if (l1) begin
                if (l1_cnt != '1) l1_cnt <= l1_cnt + CNT_W'(1);
            end else if (l2) begin
                if (l2_cnt != '1) l2_cnt <= l2_cnt + CNT_W'(1);
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end
endmodule

module cache_access_profiler #(
    parameter int          ADDR_W    = 11,
    parameter int          NUM_CH    = 3,
    parameter int          CNT_W     = 32,
    parameter int          RESP_LAT  = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_acc,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ADDR_W-1:0] ws_mask,
    output logic [ADDR_W-1:0] addr,
    output logic              read,
    input  logic [NUM_CH-1:0] l1_hit,
    input  logic [NUM_CH-1:0] l2_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  acc_cnt,
    input  logic [CH_W-1:0]   stat_ch,
    input  logic [1:0]        stat_sel,
    output logic [CNT_W-1:0]  stat_data
);
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
    localparam int          WC_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(RESP_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SAMPLE, S_DONE} state_t;

    typedef struct packed {
        logic [1:0]        mode;
        logic [CNT_W-1:0]  num_acc;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] stride;
        logic [ADDR_W-1:0] mask;
    } cfg_t;

    state_t            state;
    cfg_t              cfg;
    logic [15:0]       lfsr;
    logic [ADDR_W-1:0] seq_addr;   // base + k*stride for the next access
    logic [WC_W-1:0]   wait_cnt;

    logic [NUM_CH-1:0][CNT_W-1:0] l1_cnt, l2_cnt, miss_cnt;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // LFSR bits mapped onto the address bus; bits beyond 16 stay zero
    function automatic logic [ADDR_W-1:0] lfsr_addr(input logic [15:0] s);
        logic [ADDR_W-1:0] a;
        a = '0;
        for (int i = 0; i < ADDR_W && i < 16; i++) a[i] = s[i];
        return a;
    endfunction

    function automatic logic [ADDR_W-1:0] gen_addr(
        input logic [1:0]        m,
        input logic [15:0]       s,
        input logic [ADDR_W-1:0] sq,
        input logic [ADDR_W-1:0] b,
        input logic [ADDR_W-1:0] k
    );
        case (m)
            2'd0:    return lfsr_addr(s);
            2'd2:    return (lfsr_addr(s) & k) | (b & ~k);
            default: return sq;
        endcase
    endfunction

    logic start_ok, smp_en;
    assign start_ok = (state == S_IDLE || state == S_DONE) && start;
    // an abort landing on SAMPLE drops the in-flight access
    assign smp_en   = (state == S_SAMPLE) && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cfg      <= '0;
            lfsr     <= SEED;
            seq_addr <= '0;
            wait_cnt <= '0;
            addr     <= '0;
            read     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cfg     <= '{mode, num_acc, base_addr, stride, ws_mask};
                        acc_cnt <= '0;
                        if (num_acc == '0) begin
                            state <= S_DONE;
                            lfsr  <= SEED;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            // first access is issued straight from the start
                            // inputs so read rises in the cycle after start
                            state    <= S_ISSUE;
                            done     <= 1'b0;
                            busy     <= 1'b1;
                            read     <= 1'b1;
                            addr     <= gen_addr(mode, SEED, base_addr, base_addr, ws_mask);
                            lfsr     <= lfsr_step(SEED);
                            seq_addr <= base_addr + stride;
                        end
                    end
                end
                S_ISSUE: begin
                    read     <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (abort) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt + CNT_W'(1) == cfg.num_acc) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_ISSUE;
                            read     <= 1'b1;
                            addr     <= gen_addr(cfg.mode, lfsr, seq_addr, cfg.base, cfg.mask);
                            lfsr     <= lfsr_step(lfsr);
                            seq_addr <= seq_addr + cfg.stride;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        cache_access_profiler_lane #(.CNT_W(CNT_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (start_ok),
            .smp      (smp_en),
            .l1       (l1_hit[c]),
            .l2       (l2_hit[c]),
            .l1_cnt   (l1_cnt[c]),
            .l2_cnt   (l2_cnt[c]),
            .miss_cnt (miss_cnt[c])
        );
    end

    always_comb begin
        stat_data = '0;
        if (int'(stat_ch) < NUM_CH) begin
            case (stat_sel)
                2'd0:    stat_data = l1_cnt[stat_ch];
                2'd1:    stat_data = l2_cnt[stat_ch];
                2'd2:    stat_data = miss_cnt[stat_ch];
                default: stat_data = acc_cnt;
            endcase
        end
    end
endmodule
